// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words drained from the FIFO.
// The master drives valid/data, the slave drives ready.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: one-cycle-latency reads are absorbed by a
// 2-entry buffer so the stream can run at one word per cycle.
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    fifo_rd_stream_if.master m_if,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    logic [1:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [CNT_W-1:0] wc_q, wc_d;

    logic       pop;
    logic [1:0] occ;
    logic [1:0] rem;

    always_comb begin
        pop = (cnt_q != 2'd0) & m_if.m_ready;
        occ = cnt_q + {1'b0, pend_q};
        rem = cnt_q - {1'b0, pop};

        // A pop frees a slot this cycle, so a full buffer can still issue.
        fifo_rd_en = !rst & en & !fifo_empty
                     & ((occ < 2'd2) | pop);

        pend_d = fifo_rd_en;
        cnt_d  = rem + {1'b0, pend_q};
        wc_d   = wc_q + CNT_W'(pop);
        e0_d   = e0_q;
        e1_d   = e1_q;

        if (pop) begin
            e0_d = e1_q;
        end

        // Returning word lands at the tail of what survives the pop.
        if (pend_q) begin
            if (rem == 2'd0) begin
                e0_d = fifo_data;
            end else begin
                e1_d = fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            pend_q <= 1'b0;
            e0_q   <= '0;
            e1_q   <= '0;
            wc_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            e0_q   <= e0_d;
            e1_q   <= e1_d;
            wc_q   <= wc_d;
        end
    end

    assign m_if.m_valid = (cnt_q != 2'd0);
    assign m_if.m_data  = e0_q;
    assign word_cnt     = wc_q;
    assign busy         = (cnt_q != 2'd0) | pend_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, randomized
// traffic, delivered stream compared against write order.
module tb_fifo_rd_stream;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        rd_en4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
    logic        busy;
    logic        busy4;
    logic        force_empty;

    fifo_rd_stream_if #(.WIDTH(8)) s_if ();
    fifo_rd_stream_if #(.WIDTH(8)) s4_if ();

    assign s4_if.m_ready = s_if.m_ready;

    fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_if       (s_if),
        .word_cnt   (word_cnt),
        .busy       (busy)
    );

    fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (rd_en4),
        .m_if       (s4_if),
        .word_cnt   (word_cnt4),
        .busy       (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: queue contents, data returned one cycle after rd_en.
    logic [7:0] fq[$];
    logic [7:0] wr[$];
    logic [7:0] got[$];
    int         rdcyc[$];
    int         vcyc[$];

    initial fifo_data = 8'h00;

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int n_rd = 0;
    int issued = 0;
    int popped = 0;
    int bad_stall = 0;
    int bad_empty = 0;
    int bad_busy = 0;
    int bad_wc = 0;
    int bad_twin = 0;
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;

    function automatic int first_diff(input logic [7:0] a[$],
                                      input logic [7:0] b[$]);
        if (a.size() != b.size()) return -2;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // One clock: settle, observe, advance past the edge.
    task automatic cycle();
        fifo_empty = force_empty | (fq.size() == 0);
        #1;
        cyc_n++;
        if (fifo_rd_en === 1'b1) begin
            n_rd++;
            rdcyc.push_back(cyc_n);
            if (fifo_empty) bad_empty++;
        end
        if (!rst) begin
            if (busy !== ((issued - popped) != 0)) bad_busy++;
            if (word_cnt !== popped[15:0]) bad_wc++;
            if (word_cnt4 !== popped[3:0]) bad_wc++;
            if (rd_en4 !== fifo_rd_en || busy4 !== busy
                || s4_if.m_valid !== s_if.m_valid
                || s4_if.m_data !== s_if.m_data) bad_twin++;
        end
        if (held && (s_if.m_valid !== 1'b1
                     || s_if.m_data !== held_data)) bad_stall++;
        held = (s_if.m_valid === 1'b1) && !s_if.m_ready;
        held_data = s_if.m_data;
        if (s_if.m_valid === 1'b1 && s_if.m_ready) begin
            got.push_back(s_if.m_data);
            vcyc.push_back(cyc_n);
            popped++;
        end
        if (fifo_rd_en === 1'b1) issued++;
        @(posedge clk);
        if (rst) begin
            issued = 0;
            popped = 0;
            held = 1'b0;
        end
        #1;
    endtask

    task automatic clear_log();
        got.delete();
        vcyc.delete();
        rdcyc.delete();
        n_rd = 0;
        bad_stall = 0;
        bad_empty = 0;
        bad_busy = 0;
        bad_wc = 0;
        bad_twin = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        force_empty = 1'b0;
        cycle();
        rst = 1'b0;
        fq.delete();
        wr.delete();
        clear_log();
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        wr.push_back(v);
    endtask

    task automatic test_reset();
        fq.delete();
        wr.delete();
        for (int i = 0; i < 8; i++) push(8'(i));
        rst = 1'b1;
        en = 1'b1;
        s_if.m_ready = 1'b1;
        force_empty = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en);
            end
            checks++;
            if (s_if.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid got %b exp 0", s_if.m_valid);
            end
            checks++;
            if (word_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_cnt got %0d exp 0", word_cnt);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy got %b exp 0", busy);
            end
        end
        checks++;
        if (fq.size() != 8) begin
            errors++;
            $display("FAIL reset_fifo got %0d exp 8", fq.size());
        end
    endtask

    task automatic test_stream();
        int d;
        rst = 1'b0;
        clear_log();
        for (int c = 0; c < 14; c++) cycle();
        checks++;
        if (n_rd != 8) begin
            errors++;
            $display("FAIL stream_nrd got %0d exp 8", n_rd);
        end
        checks++;
        if (rdcyc.size() != 8 || rdcyc[7] - rdcyc[0] != 7) begin
            errors++;
            $display("FAIL stream_rd_run got %0d pulses exp 8 back-to-back",
                     rdcyc.size());
        end
        checks++;
        if (vcyc.size() != 8 || rdcyc.size() == 0
            || vcyc[0] - rdcyc[0] != 2 || vcyc[7] - vcyc[0] != 7) begin
            errors++;
            $display("FAIL stream_latency got %0d words exp 8 from rd+2",
                     vcyc.size());
        end
        d = first_diff(got, wr);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stream_order got diff %0d (n=%0d) exp -1",
                     d, got.size());
        end
        checks++;
        if (word_cnt !== 16'd8) begin
            errors++;
            $display("FAIL stream_cnt got %0d exp 8", word_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_busy got %b exp 0", busy);
        end
        checks++;
        if (bad_stall + bad_empty + bad_busy + bad_wc + bad_twin != 0) begin
            errors++;
            $display("FAIL stream_rules got %0d/%0d/%0d/%0d/%0d exp 0",
                     bad_stall, bad_empty, bad_busy, bad_wc, bad_twin);
        end
    endtask

    task automatic test_backpressure();
        int d;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(i));
        en = 1'b1;
        s_if.m_ready = 1'b0;
        for (int c = 0; c < 8; c++) cycle();
        checks++;
        if (n_rd != 2) begin
            errors++;
            $display("FAIL bp_nrd got %0d exp 2", n_rd);
        end
        checks++;
        if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'd0) begin
            errors++;
            $display("FAIL bp_head got %b/%0d exp 1/0",
                     s_if.m_valid, s_if.m_data);
        end
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 14; c++) cycle();
        d = first_diff(got, wr);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bp_order got diff %0d exp -1", d);
        end
        checks++;
        if (vcyc.size() != 8 || vcyc[7] - vcyc[0] != 7) begin
            errors++;
            $display("FAIL bp_gapless got %0d words exp 8 consecutive",
                     vcyc.size());
        end
        checks++;
        if (bad_stall + bad_empty + bad_busy + bad_wc + bad_twin != 0) begin
            errors++;
            $display("FAIL bp_rules got %0d/%0d/%0d/%0d/%0d exp 0",
                     bad_stall, bad_empty, bad_busy, bad_wc, bad_twin);
        end
    endtask

    task automatic test_empty_toggle();
        int d;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 48; c++) begin
            force_empty = ((c / 2) % 2) == 1;
            if (c < 40 && $urandom_range(0, 1) == 1) push(8'($urandom));
            s_if.m_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        force_empty = 1'b0;
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 12; c++) cycle();
        d = first_diff(got, wr);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL toggle_order got diff %0d (n=%0d) exp -1 (n=%0d)",
                     d, got.size(), wr.size());
        end
        checks++;
        if (bad_empty != 0) begin
            errors++;
            $display("FAIL toggle_rd_when_empty got %0d exp 0", bad_empty);
        end
        checks++;
        if (bad_stall + bad_busy + bad_wc + bad_twin != 0) begin
            errors++;
            $display("FAIL toggle_rules got %0d/%0d/%0d/%0d exp 0",
                     bad_stall, bad_busy, bad_wc, bad_twin);
        end
    endtask

    task automatic test_en_off();
        int d;
        int outstanding;
        int base;
        int rd0;
        do_reset();
        for (int i = 0; i < 12; i++) push(8'($urandom));
        en = 1'b1;
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        en = 1'b0;
        outstanding = issued - popped;
        base = got.size();
        rd0 = n_rd;
        for (int c = 0; c < 6; c++) cycle();
        checks++;
        if (got.size() - base != outstanding) begin
            errors++;
            $display("FAIL enoff_drain got %0d exp %0d",
                     got.size() - base, outstanding);
        end
        checks++;
        if (n_rd != rd0 || s_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enoff_idle got rd=%0d v=%b b=%b exp 0/0/0",
                     n_rd - rd0, s_if.m_valid, busy);
        end
        en = 1'b1;
        for (int c = 0; c < 20; c++) cycle();
        d = first_diff(got, wr);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL enoff_resume got diff %0d exp -1", d);
        end
        checks++;
        if (bad_stall + bad_empty + bad_busy + bad_wc + bad_twin != 0) begin
            errors++;
            $display("FAIL enoff_rules got %0d/%0d/%0d/%0d/%0d exp 0",
                     bad_stall, bad_empty, bad_busy, bad_wc, bad_twin);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        logic [7:0] exp[$];
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(i));
        en = 1'b1;
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (s_if.m_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_clear got v=%b b=%b n=%0d exp 0/0/0",
                     s_if.m_valid, busy, word_cnt);
        end
        rst = 1'b0;
        en = 1'b0;
        exp = fq;
        clear_log();
        for (int c = 0; c < 3; c++) cycle();
        checks++;
        if (s_if.m_valid !== 1'b0 || got.size() != 0) begin
            errors++;
            $display("FAIL midrst_drop got v=%b n=%0d exp 0/0",
                     s_if.m_valid, got.size());
        end
        en = 1'b1;
        for (int c = 0; c < 16; c++) cycle();
        d = first_diff(got, exp);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL midrst_order got diff %0d (n=%0d) exp -1 (n=%0d)",
                     d, got.size(), exp.size());
        end
    endtask

    task automatic test_random();
        int d;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c < 350 && $urandom_range(0, 1) == 1) push(8'($urandom));
            en = $urandom_range(0, 4) != 0;
            s_if.m_ready = $urandom_range(0, 2) != 0;
            force_empty = $urandom_range(0, 7) == 0;
            cycle();
        end
        en = 1'b1;
        s_if.m_ready = 1'b1;
        force_empty = 1'b0;
        for (int c = 0; c < 200 && got.size() < wr.size(); c++) cycle();
        for (int c = 0; c < 4; c++) cycle();
        d = first_diff(got, wr);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL random_order got diff %0d (n=%0d) exp -1 (n=%0d)",
                     d, got.size(), wr.size());
        end
        checks++;
        if (bad_stall + bad_empty + bad_busy + bad_wc + bad_twin != 0) begin
            errors++;
            $display("FAIL random_rules got %0d/%0d/%0d/%0d/%0d exp 0",
                     bad_stall, bad_empty, bad_busy, bad_wc, bad_twin);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) push(8'($urandom));
        en = 1'b1;
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 24; c++) cycle();
        checks++;
        if (word_cnt !== 16'd17) begin
            errors++;
            $display("FAIL wrap_cnt16 got %0d exp 17", word_cnt);
        end
        checks++;
        if (word_cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cnt4 got %0d exp 1", word_cnt4);
        end
        checks++;
        if (got.size() != 17) begin
            errors++;
            $display("FAIL wrap_words got %0d exp 17", got.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        force_empty = 1'b0;
        fifo_empty = 1'b1;
        s_if.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_toggle();
        test_en_off();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
